// File: rtl/deal_pkg.sv
// Shared types and constants for the card deal sequencer.
// Optional DEAL_SEQ_RR_EN selects round-robin arbitration.
package deal_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    CLEAR,
    HOLD,
    DONE
  } state_t;

  localparam int CARD_MAX = 13;
  localparam int PLAYER   = 0;
  localparam int DEALER   = 1;

endpackage

// File: rtl/card_mod13.sv
// Maps a free-running count onto a card value 1..13.
// Exact remainder over the whole count range.
module card_mod13
  import deal_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] i_Count,
  output logic [3:0]       o_Card
);

  assign o_Card = 4'(i_Count % WIDTH'(CARD_MAX)) + 4'd1;

endmodule

// File: rtl/deal_sequencer.sv
// Draw sequencer: arbitrate, capture a card, clear and hold the counter.
// Define DEAL_SEQ_RR_EN for round-robin arbitration.
module deal_sequencer
  import deal_pkg::*;
#(
  parameter int WIDTH   = 12,
  parameter int NUM_REQ = 2
) (
  input  logic               clk_50M,
  input  logic               i_Reset_n,
  input  logic [NUM_REQ-1:0] i_Req,
  input  logic [WIDTH-1:0]   i_Count,
  input  logic               i_TwoSec,
  output logic               o_RstCounter,
  output logic               o_Active,
  output logic [NUM_REQ-1:0] o_Grant,
  output logic [3:0]         o_Card,
  output logic               o_Valid,
  output logic               o_Busy
);

  state_t     state, state_nx;
  logic       sel, sel_nx;
  logic       armed, armed_nx;
  logic [3:0] card, card_nx;
  logic [3:0] mod_card;
  logic       pick;

  card_mod13 #(.WIDTH(WIDTH)) u_mod (
    .i_Count (i_Count),
    .o_Card  (mod_card)
  );

`ifdef DEAL_SEQ_RR_EN
  logic prio;

  // prio names the requester favoured on a tie
  always_ff @(posedge clk_50M or negedge i_Reset_n) begin
    if (!i_Reset_n)        prio <= 1'(PLAYER);
    else if (state == DONE) prio <= ~sel;
  end

  always_comb begin
    pick = i_Req[DEALER] & ~i_Req[PLAYER];
    if (i_Req[PLAYER] && i_Req[DEALER]) pick = prio;
  end
`else
  always_comb pick = ~i_Req[PLAYER];
`endif

  always_ff @(posedge clk_50M or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state <= IDLE;
      sel   <= 1'(PLAYER);
      armed <= 1'b0;
      card  <= 4'd0;
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
      armed <= armed_nx;
      card  <= card_nx;
    end
  end

  // HOLD only finishes on a flag that was seen low first
  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    armed_nx = armed;
    card_nx  = card;
    case (state)
      IDLE: begin
        if (|i_Req) begin
          sel_nx   = pick;
          state_nx = CAPTURE;
        end
      end
      CAPTURE: begin
        card_nx  = mod_card;
        state_nx = CLEAR;
      end
      CLEAR: begin
        armed_nx = 1'b0;
        state_nx = HOLD;
      end
      HOLD: begin
        if (armed && i_TwoSec) state_nx = DONE;
        else if (!i_TwoSec)    armed_nx = 1'b1;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_Grant = '0;
    if (state != IDLE) o_Grant[sel] = 1'b1;
  end

  assign o_Busy       = (state != IDLE);
  assign o_RstCounter = (state == CLEAR);
  assign o_Active     = (state == HOLD);
  assign o_Valid      = (state == DONE);
  assign o_Card       = card;

endmodule
